// File: rtl/dmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_pkg                                                         |
// | MMIO map, STATUS bit positions and offset decode for dmem_resp.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dmem_pkg;

   localparam logic [15:0] MMIO_BASE  = 16'hFFFF;

   localparam logic [7:0]  OFF_STATUS = 8'h00;
   localparam logic [7:0]  OFF_TXDATA = 8'h04;
   localparam logic [7:0]  OFF_CYCLO  = 8'h08;
   localparam logic [7:0]  OFF_CYCHI  = 8'h0C;
   localparam logic [7:0]  OFF_CLEAR  = 8'h10;

   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_FULL      = 16;
   localparam int STAT_EMPTY     = 17;
   localparam int STAT_OVF       = 24;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_STATUS,
      REG_TXDATA,
      REG_CYCLO,
      REG_CYCHI,
      REG_CLEAR
   } mmio_reg_e;

   function automatic mmio_reg_e decode_off(input logic [7:0] off);
      case (off)
         OFF_STATUS: return REG_STATUS;
         OFF_TXDATA: return REG_TXDATA;
         OFF_CYCLO:  return REG_CYCLO;
         OFF_CYCHI:  return REG_CYCHI;
         OFF_CLEAR:  return REG_CLEAR;
         default:    return REG_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder_if                                                |
// | Core memory-stage port plus the console TX byte stream.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dmem_responder_if;

   logic        MemWrite;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        TxValid;
   logic [7:0]  TxData;
   logic        TxReady;

   modport master (
      output MemWrite, MemAddr, MemWData, TxReady,
      input  MemRData, TxValid, TxData
   );

   modport slave (
      input  MemWrite, MemAddr, MemWData, TxReady,
      output MemRData, TxValid, TxData
   );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_tx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tx_fifo                                                          |
// | Byte FIFO for console transmit; head forced to 0 while empty.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tx_fifo #(
   parameter int FIFO_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [7:0]           wdata,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [FIFO_LOG2:0]   count,
   output logic [7:0]           head
);

   localparam int                 DEPTH      = 2 ** FIFO_LOG2;
   localparam logic [FIFO_LOG2:0] FULL_COUNT = {1'b1, {FIFO_LOG2{1'b0}}};

   logic [7:0]           mem_q [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_LOG2:0]   count_q,  count_d;
   logic                 do_push;
   logic                 do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign count   = count_q;
   assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_LOG2'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_LOG2'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (FIFO_LOG2 + 1)'(1);
         2'b01:   count_d = count_q - (FIFO_LOG2 + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_responder                                                   |
// | Zero-latency data RAM plus MMIO cycle counter and console FIFO.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int FIFO_LOG2  = 4
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);

   logic [31:0]           ram_q [2 ** DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic                  is_mmio;
   mmio_reg_e             reg_sel;
   logic                  wr_tx;
   logic                  wr_clear;
   logic                  unused_addr;

   logic [63:0]           cyc_q, cyc_d;
   logic                  ovf_q, ovf_d;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [FIFO_LOG2:0]    fifo_count;
   logic [7:0]            fifo_head;
   logic [31:0]           status;
   logic [31:0]           rdata;

   assign ram_idx     = bus.MemAddr[DEPTH_LOG2+1:2];
   assign is_mmio     = (bus.MemAddr[31:16] == MMIO_BASE);
   assign reg_sel     = is_mmio ? decode_off(bus.MemAddr[7:0]) : REG_NONE;
   assign wr_tx       = bus.MemWrite & (reg_sel == REG_TXDATA);
   assign wr_clear    = bus.MemWrite & (reg_sel == REG_CLEAR);
   assign unused_addr = ^bus.MemAddr;

   assign fifo_push   = wr_tx & ~fifo_full;
   assign fifo_pop    = ~fifo_empty & bus.TxReady;

   tx_fifo #(
      .FIFO_LOG2 (FIFO_LOG2)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (bus.MemWData[7:0]),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count),
      .head  (fifo_head)
   );

   assign bus.TxValid = ~fifo_empty;
   assign bus.TxData  = fifo_head;

   // Set and clear cannot coincide: only one access per cycle.
   always_comb begin
      cyc_d = cyc_q + 64'd1;
      ovf_d = ovf_q;
      if (wr_tx && fifo_full) ovf_d = 1'b1;
      if (wr_clear)           ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cyc_q <= cyc_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (bus.MemWrite && !is_mmio) ram_q[ram_idx] <= bus.MemWData;
   end

   always_comb begin
      status                              = '0;
      status[STAT_COUNT_LSB+:FIFO_LOG2+1] = fifo_count;
      status[STAT_FULL]                   = fifo_full;
      status[STAT_EMPTY]                  = fifo_empty;
      status[STAT_OVF]                    = ovf_q;
   end

   always_comb begin
      rdata = ram_q[ram_idx];
      if (is_mmio) begin
         case (reg_sel)
            REG_STATUS: rdata = status;
            REG_CYCLO:  rdata = cyc_q[31:0];
            REG_CYCHI:  rdata = cyc_q[63:32];
            default:    rdata = 32'h0;
         endcase
      end
   end

   assign bus.MemRData = rdata;

endmodule
`default_nettype wire
